// File: rtl/complex_nr_mult_stim_gen_pkg.sv
// Shared encodings and constants for the complex multiplier stimulus generator.
// Also holds the LFSR step so every user advances it the same way.
package complex_nr_mult_stim_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_PULSE = 3'd1,
        ST_LOAD      = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_RES  = 3'd4,
        ST_CHECK     = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    localparam logic [1:0] MODE_FIXED  = 2'd0;
    localparam logic [1:0] MODE_RANDOM = 2'd1;
    localparam logic [1:0] MODE_CORNER = 2'd2;
    localparam logic [1:0] MODE_SWEEP  = 2'd3;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam int FIXED_OP1_RE = 2;
    localparam int FIXED_OP1_IM = 3;
    localparam int FIXED_OP2_RE = 4;
    localparam int FIXED_OP2_IM = 2;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/complex_nr_ref_model.sv
// Combinational reference complex product of the packed operand word.
// Result components are full width, so no overflow or truncation occurs.
module complex_nr_ref_model
    import complex_nr_mult_stim_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic        [4*DATA_WIDTH-1:0] op_data,
    output logic signed [2*DATA_WIDTH:0]   exp_re,
    output logic signed [2*DATA_WIDTH:0]   exp_im
);

    localparam int PW = 2*DATA_WIDTH + 1;

    logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;
    logic signed [PW-1:0]         p_rr, p_ii, p_ri, p_ir;

    always_comb begin
        a_re = op_data[4*DATA_WIDTH-1 -: DATA_WIDTH];
        a_im = op_data[3*DATA_WIDTH-1 -: DATA_WIDTH];
        b_re = op_data[2*DATA_WIDTH-1 -: DATA_WIDTH];
        b_im = op_data[DATA_WIDTH-1   -: DATA_WIDTH];
        p_rr = PW'(a_re) * PW'(b_re);
        p_ii = PW'(a_im) * PW'(b_im);
        p_ri = PW'(a_re) * PW'(b_im);
        p_ir = PW'(a_im) * PW'(b_re);
        exp_re = p_rr - p_ii;
        exp_im = p_ri + p_ir;
    end

endmodule

// File: rtl/complex_nr_mult_stim_gen.sv
// Drives operand transactions into a complex multiplier, checks each result
// against a reference model and tallies pass/error counts per run.
module complex_nr_mult_stim_gen
    import complex_nr_mult_stim_gen_pkg::*;
#(
    parameter int          DATA_WIDTH     = 8,
    parameter int          CNT_WIDTH      = 10,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_2468
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [CNT_WIDTH-1:0]      num_trans,
    input  logic                      op_ready,
    input  logic                      res_val,
    input  logic [4*DATA_WIDTH+1:0]   res_data,
    output logic                      sw_rst,
    output logic                      op_val,
    output logic [4*DATA_WIDTH-1:0]   op_data,
    output logic                      res_ready,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_WIDTH-1:0]      pass_cnt,
    output logic [CNT_WIDTH-1:0]      err_cnt,
    output logic                      timeout_err,
    output state_t                    state_dbg
);

    localparam int                   RW       = 2*DATA_WIDTH + 1;
    localparam int                   TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]        TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    state_t                  state;
    logic [1:0]              mode_q;
    logic [CNT_WIDTH-1:0]    num_q;
    logic [CNT_WIDTH-1:0]    idx_q;
    logic [31:0]             lfsr;
    logic [TW-1:0]           to_cnt;
    logic [2*RW-1:0]         exp_r;
    logic [2*RW-1:0]         res_r;
    logic [4*DATA_WIDTH-1:0] ops_next;
    logic signed [RW-1:0]    ref_re;
    logic signed [RW-1:0]    ref_im;

    assign state_dbg = state;

    always_comb begin
        ops_next = '0;
        case (mode_q)
            MODE_FIXED:  ops_next = {DATA_WIDTH'(FIXED_OP1_RE), DATA_WIDTH'(FIXED_OP1_IM),
                                     DATA_WIDTH'(FIXED_OP2_RE), DATA_WIDTH'(FIXED_OP2_IM)};
            MODE_RANDOM: ops_next = lfsr[4*DATA_WIDTH-1:0];
            MODE_CORNER: ops_next = '1;
            MODE_SWEEP:  ops_next = {4{idx_q[DATA_WIDTH-1:0]}};
            default:     ops_next = '0;
        endcase
    end

    complex_nr_ref_model #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ref (
        .op_data (ops_next),
        .exp_re  (ref_re),
        .exp_im  (ref_im)
    );

    // Handshakes: a word moves on a rising edge where valid and ready are both
    // high; valid holds its data stable until then and never waits on ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            mode_q      <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            lfsr        <= LFSR_SEED;
            to_cnt      <= '0;
            exp_r       <= '0;
            res_r       <= '0;
            sw_rst      <= 1'b0;
            op_val      <= 1'b0;
            op_data     <= '0;
            res_ready   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass_cnt    <= '0;
            err_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_RST_PULSE;
                        mode_q      <= mode;
                        num_q       <= num_trans;
                        idx_q       <= '0;
                        done        <= 1'b0;
                        pass_cnt    <= '0;
                        err_cnt     <= '0;
                        timeout_err <= 1'b0;
                        sw_rst      <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ST_RST_PULSE: begin
                    sw_rst <= 1'b0;
                    if (num_q == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    op_data <= ops_next;
                    exp_r   <= {ref_re, ref_im};
                    if (mode_q == MODE_RANDOM) begin
                        lfsr <= lfsr_step(lfsr);
                    end
                    op_val  <= 1'b1;
                    to_cnt  <= '0;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (op_ready) begin
                        op_val    <= 1'b0;
                        res_ready <= 1'b1;
                        to_cnt    <= '0;
                        state     <= ST_WAIT_RES;
                    end else if (to_cnt == TO_LAST) begin
                        op_val      <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_WAIT_RES: begin
                    if (res_val) begin
                        res_r     <= res_data;
                        res_ready <= 1'b0;
                        state     <= ST_CHECK;
                    end else if (to_cnt == TO_LAST) begin
                        res_ready   <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (res_r == exp_r) begin
                        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
                    end else begin
                        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
                    end
                    idx_q <= idx_q + 1'b1;
                    if (idx_q + 1'b1 == num_q) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_complex_nr_mult_stim_gen.sv
// Directed bench: a behavioural multiplier answers the generator, a queue holds
// the operand words the generator is expected to send, counters are checked per run.
module tb_complex_nr_mult_stim_gen;
    import complex_nr_mult_stim_gen_pkg::*;

    localparam int DW = 8;
    localparam int CW = 10;
    localparam int RW = 2*DW + 1;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic [CW-1:0]   num_trans = '0;
    logic            op_ready = 1'b0;
    logic            res_val = 1'b0;
    logic [4*DW+1:0] res_data = '0;
    logic            sw_rst, op_val, res_ready, busy, done, timeout_err;
    logic [4*DW-1:0] op_data;
    logic [CW-1:0]   pass_cnt, err_cnt;
    state_t          state_dbg;

    complex_nr_mult_stim_gen #(
        .DATA_WIDTH     (DW),
        .CNT_WIDTH      (CW),
        .TIMEOUT_CYCLES (64),
        .LFSR_SEED      (32'hACE1_2468)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .mode        (mode),
        .num_trans   (num_trans),
        .op_ready    (op_ready),
        .res_val     (res_val),
        .res_data    (res_data),
        .sw_rst      (sw_rst),
        .op_val      (op_val),
        .op_data     (op_data),
        .res_ready   (res_ready),
        .busy        (busy),
        .done        (done),
        .pass_cnt    (pass_cnt),
        .err_cnt     (err_cnt),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              failures = 0;
    logic [31:0]     exp_q[$];
    logic [31:0]     lfsr_m = 32'hACE1_2468;
    logic [2*RW-1:0] res_word = '0;
    logic [31:0]     held = '0;
    bit              pend = 0, res_fired = 0, seen = 0, taken = 0, tmo = 0;
    int              stall_cnt = 0, sw_pulses = 0, send_cycles = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [2*RW-1:0] cmul(input logic [31:0] op);
        int a, b, c, d, re, im;
        a  = int'($signed(op[31:24]));
        b  = int'($signed(op[23:16]));
        c  = int'($signed(op[15:8]));
        d  = int'($signed(op[7:0]));
        re = a*c - b*d;
        im = a*d + b*c;
        return {re[RW-1:0], im[RW-1:0]};
    endfunction

    task automatic flush_responder(input bit clear_sb);
        res_val = 1'b0; op_ready = 1'b0;
        pend = 0; res_fired = 0; seen = 0; taken = 0; stall_cnt = 0;
        if (clear_sb) exp_q.delete();
    endtask

    task automatic do_start(input logic [1:0] m, input logic [CW-1:0] n);
        @(negedge clk);
        flush_responder(0);
        start = 1'b1; mode = m; num_trans = n;
        sw_pulses = 0; send_cycles = 0;
    endtask

    // Behavioural multiplier: answers each operand word with its product.
    task automatic serve(input int max_cyc, input int stall, input bit tie0,
                         input bit bad_re, input bit stop_wait, output bit timed_out);
        logic [2*RW-1:0] r;
        timed_out = 1;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (sw_rst) sw_pulses++;
            if (op_val) send_cycles++;
            if (stop_wait && res_ready) begin timed_out = 0; break; end
            if (done && !busy) begin timed_out = 0; break; end
            if (res_fired) begin res_val = 1'b0; res_fired = 0; end
            if (pend && !res_val) begin res_val = 1'b1; res_data = res_word; pend = 0; end
            if (res_val && res_ready) res_fired = 1;
            if (taken) begin op_ready = 1'b0; taken = 0; seen = 0; stall_cnt = 0; end
            if (op_val) begin
                if (seen) check("op_stable", op_data, held);
                else begin held = op_data; seen = 1; end
                if (tie0 || stall_cnt < stall) begin
                    op_ready = 1'b0; stall_cnt++;
                end else begin
                    op_ready = 1'b1; taken = 1;
                    if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                    else check("op_data", op_data, exp_q.pop_front());
                    r = cmul(op_data);
                    if (bad_re) r[2*RW-1:RW] = RW'(3);
                    res_word = r; pend = 1;
                end
            end else begin
                op_ready = 1'b0;
            end
        end
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_sw_rst"}, sw_rst, 0);
        check({pfx, "_op_val"}, op_val, 0);
        check({pfx, "_op_data"}, op_data, 0);
        check({pfx, "_res_ready"}, res_ready, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_pass"}, pass_cnt, 0);
        check({pfx, "_err"}, err_cnt, 0);
        check({pfx, "_timeout"}, timeout_err, 0);
        check({pfx, "_state"}, state_dbg, ST_IDLE);
    endtask

    task automatic check_end(input string pfx, input int p, input int e, input bit t);
        check({pfx, "_pass"}, pass_cnt, p);
        check({pfx, "_err"}, err_cnt, e);
        check({pfx, "_done"}, done, 1);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_timeout"}, timeout_err, t);
        check({pfx, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_quiet("rst");
        rstn = 1'b1;

        // Random mode straight after reset, with a 5-cycle stall on every operand
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(lfsr_m);
            lfsr_m = lfsr_next(lfsr_m);
        end
        do_start(2'd1, 10'd3);
        serve(2000, 5, 0, 0, 0, tmo);
        check("m1_wait", tmo, 0);
        check_end("m1", 3, 0, 0);
        check("m1_sw_rst", sw_pulses, 1);

        // Fixed operands: (2+3j)(4+2j) = 2+16j
        exp_q.push_back(32'h0203_0402);
        do_start(2'd0, 10'd1);
        serve(200, 0, 0, 0, 0, tmo);
        check("m0_wait", tmo, 0);
        check_end("m0", 1, 0, 0);

        // Corner: all components -1, product 0+2j
        exp_q.push_back(32'hFFFF_FFFF);
        do_start(2'd2, 10'd1);
        serve(200, 0, 0, 0, 0, tmo);
        check("m2_wait", tmo, 0);
        check_end("m2", 1, 0, 0);

        // Faulty responder returns re=3
        exp_q.push_back(32'h0203_0402);
        do_start(2'd0, 10'd1);
        serve(200, 0, 0, 1, 0, tmo);
        check("bad_wait", tmo, 0);
        check_end("bad", 0, 1, 0);

        // A result offered outside WAIT_RES is neither taken nor counted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            res_val = 1'b1; res_data = cmul(32'h0203_0402);
            check("stray_res_ready", res_ready, 0);
        end
        @(negedge clk);
        res_val = 1'b0;
        check("stray_pass", pass_cnt, 0);
        check("stray_err", err_cnt, 1);

        // Sweep of 5, with a second start while busy that must be ignored
        for (int i = 0; i < 5; i++) exp_q.push_back({4{i[7:0]}});
        do_start(2'd3, 10'd5);
        @(negedge clk);
        start = 1'b1; mode = 2'd0; num_trans = 10'd1;
        serve(500, 0, 0, 0, 0, tmo);
        check("m3_wait", tmo, 0);
        check_end("m3", 5, 0, 0);

        // Zero-length run: one reset pulse, then done
        do_start(2'd0, 10'd0);
        serve(50, 0, 0, 0, 0, tmo);
        check("zero_wait", tmo, 0);
        check_end("zero", 0, 0, 0);
        check("zero_sw_rst", sw_pulses, 1);
        check("zero_send", send_cycles, 0);

        // Operand side never ready: timeout after 64 SEND cycles
        do_start(2'd0, 10'd1);
        serve(500, 0, 1, 0, 0, tmo);
        check("tmo_wait", tmo, 0);
        check_end("tmo", 0, 0, 1);
        check("tmo_op_val", op_val, 0);
        check("tmo_send", send_cycles, 64);

        // Reset while waiting on the first sweep result, then a fresh sweep
        for (int i = 0; i < 3; i++) exp_q.push_back({4{i[7:0]}});
        do_start(2'd3, 10'd3);
        serve(200, 0, 0, 0, 1, tmo);
        check("mid_wait", tmo, 0);
        check("mid_in_wait", state_dbg, ST_WAIT_RES);
        rstn = 1'b0;
        #1;
        check_quiet("mid_rst");
        flush_responder(1);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 2; i++) exp_q.push_back({4{i[7:0]}});
        do_start(2'd3, 10'd2);
        serve(200, 0, 0, 0, 0, tmo);
        check("post_wait", tmo, 0);
        check_end("post", 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/complex_nr_mult_stim_gen.md
COMPLEX_NR_MULT_STIM_GEN -- requirements
Module: complex_nr_mult_stim_gen

Interface
REQ-001 Parameter DATA_WIDTH, 8, operand component width in bits, legal range 2..8.
REQ-002 Parameter CNT_WIDTH, 10, width of transaction and result counters.
REQ-003 Parameter TIMEOUT_CYCLES, 64, maximum cycles spent waiting on either handshake.
REQ-004 Parameter LFSR_SEED, 32'hACE1_2468, nonzero LFSR reset value.
REQ-005 clk  in  1  single clock, all logic on posedge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle request to begin a run.
REQ-008 mode  in  2  stimulus mode, sampled on accepted start.
REQ-009 num_trans  in  CNT_WIDTH  transaction count, sampled on accepted start.
REQ-010 op_ready  in  1  DUT can accept operands.
REQ-011 res_val  in  1  DUT result valid.
REQ-012 res_data  in  4*DATA_WIDTH+2  DUT result {re, im}, each 2*DATA_WIDTH+1 signed.
REQ-013 sw_rst  out  1  software reset to DUT, active 1.
REQ-014 op_val  out  1  operands valid.
REQ-015 op_data  out  4*DATA_WIDTH  {op1_re, op1_im, op2_re, op2_im}, signed two's complement.
REQ-016 res_ready  out  1  generator can accept result.
REQ-017 busy  out  1  run in progress.
REQ-018 done  out  1  run finished, held until next accepted start.
REQ-019 pass_cnt  out  CNT_WIDTH  results matching expected value.
REQ-020 err_cnt  out  CNT_WIDTH  results mismatching expected value.
REQ-021 timeout_err  out  1  sticky, a handshake exceeded TIMEOUT_CYCLES.

Function
REQ-022 FSM states IDLE, RST_PULSE, LOAD, SEND, WAIT_RES, CHECK, DONE.
REQ-023 IDLE/DONE: start accepted -> RST_PULSE; clear done, pass_cnt, err_cnt, timeout_err; latch mode, num_trans.
REQ-024 start while busy is ignored.
REQ-025 RST_PULSE: sw_rst=1 exactly one cycle; then DONE if latched num_trans==0, else LOAD.
REQ-026 LOAD: one cycle; compute operands per mode, register op_data and expected result.
REQ-027 Mode 0 fixed: operands (2,3,4,2).
REQ-028 Mode 1 random: op_data = LFSR[4*DATA_WIDTH-1:0]; 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advanced once per LOAD; not reseeded on start.
REQ-029 Mode 2 corner: all components all-ones (-1).
REQ-030 Mode 3 sweep: all four components = transaction index modulo 2^DATA_WIDTH, starting at 0.
REQ-031 Expected re = op1_re*op2_re - op1_im*op2_im, im = op1_re*op2_im + op1_im*op2_re, signed, full 2*DATA_WIDTH+1 width, no truncation.
REQ-032 SEND: op_val=1, op_data stable; transfer on posedge with op_val&&op_ready -> WAIT_RES, op_val=0 next cycle.
REQ-033 WAIT_RES: res_ready=1; transfer on res_val&&res_ready -> capture res_data, go CHECK.
REQ-034 res_val while not in WAIT_RES is not accepted and not counted.
REQ-035 CHECK: one cycle; increment pass_cnt on exact match else err_cnt; counters saturate at all-ones.
REQ-036 CHECK: transactions done == num_trans -> DONE, else LOAD.
REQ-037 Timeout counter cleared on entry to SEND and WAIT_RES; reaching TIMEOUT_CYCLES in either -> set timeout_err, drop op_val/res_ready, go DONE.
REQ-038 DONE: done=1, busy=0; busy=1 in all states except IDLE and DONE.
REQ-039 Latency per transaction with op_ready and res_val held high: LOAD to CHECK = 4 cycles.

Reset
REQ-040 rstn low, at any time incl. mid-run, forces IDLE immediately; all outputs 0, op_data 0, LFSR = LFSR_SEED, counters 0.
REQ-041 No output glitches to 1 during reset; outputs registered.

Structure
REQ-042 Shared package holds FSM state encoding, mode encodings, LFSR polynomial constant, fixed mode-0 operands.
REQ-043 One sub-module complex_nr_ref_model: combinational expected-result computation per REQ-031.

Verification
REQ-044 mode0, num_trans=1, DUT ideal -> op_data=0x02030402, expected re=2, im=16, pass_cnt=1, err_cnt=0, done=1.
REQ-045 mode2, DATA_WIDTH=8, num_trans=1 -> op_data=0xFFFFFFFF, expected re=0, im=2, pass_cnt=1.
REQ-046 mode1, num_trans=3, op_ready low 5 cycles each transfer -> op_data stable while op_val high, 3 distinct LFSR vectors, pass_cnt=3.
REQ-047 mode0, DUT returns re=3 -> err_cnt=1, pass_cnt=0, done=1.
REQ-048 op_ready tied 0 -> timeout_err=1 after 64 SEND cycles, op_val=0, done=1; num_trans=0 -> single sw_rst pulse then done, counters 0.
REQ-049 rstn asserted during WAIT_RES of mode3 run -> all outputs 0 same cycle, busy=0, new start runs from index 0.
